// File: rtl/placar_registro_pontos.sv
// Scoreboard point-entry stage: debounces point buttons, requests the adder
// operation and writes the accepted result back into the per-team score.
module placar_registro_pontos #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_SCORE       = 99,
  parameter int BUZZ_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  input  logic       btn_c_n,
  input  logic       team_sel,
  input  logic       sub_mode,
  input  logic       clear_n,
  input  logic [6:0] sum_s,
  input  logic       sum_cout,
  output logic       pts_a,
  output logic       pts_b,
  output logic       pts_c,
  output logic [6:0] n1,
  output logic       cin_o,
  output logic       team_o,
  output logic [6:0] score0,
  output logic [6:0] score1,
  output logic       buzzer
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMMIT,
    WAIT_REL
  } state_t;

  state_t state_q, state_d;

  // Button levels are kept in pressed = 1 polarity from here on.
  logic [2:0] raw;
  logic [2:0] sync1, sync2;
  logic [2:0] deb, deb_d;
  logic [CW-1:0] cnt [3];

  logic [2:0] pts;
  logic       team_q;
  logic [BW-1:0] buzz_cnt;

  logic press_ev;
  logic one_hot;
  logic take;
  logic commit;
  logic accept;
  logic wr0, wr1, rej;

  assign raw = ~{btn_c_n, btn_b_n, btn_a_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_ev = |(deb & ~deb_d);
  assign one_hot  = $onehot(deb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (press_ev) state_d = one_hot ? SETTLE : WAIT_REL;
      SETTLE:   state_d = COMMIT;
      COMMIT:   state_d = WAIT_REL;
      WAIT_REL: if (deb == 3'b000) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Clear aborts whatever is in flight.
    if (!clear_n) state_d = WAIT_REL;
  end

  always_comb begin
    take   = clear_n && (state_q == IDLE) && press_ev && one_hot;
    team_o = (state_q == IDLE) ? team_sel : team_q;
    n1     = team_o ? score1 : score0;
    commit = clear_n && (state_q == COMMIT);
    if (cin_o) accept = sum_cout;
    else       accept = !sum_cout && (sum_s <= 7'(MAX_SCORE));
    wr0 = commit && accept && !team_q;
    wr1 = commit && accept && team_q;
    rej = commit && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pts    <= '0;
      team_q <= 1'b0;
      cin_o  <= 1'b0;
    end else if (!clear_n) begin
      pts <= '0;
    end else if (take) begin
      pts    <= deb;
      team_q <= team_sel;
      cin_o  <= sub_mode;
    end else if (state_q == COMMIT) begin
      pts <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score0 <= '0;
      score1 <= '0;
    end else if (!clear_n) begin
      score0 <= '0;
      score1 <= '0;
    end else begin
      if (wr0) score0 <= sum_s;
      if (wr1) score1 <= sum_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             buzz_cnt <= '0;
    else if (rej)           buzz_cnt <= BW'(BUZZ_CYCLES);
    else if (buzz_cnt != 0) buzz_cnt <= buzz_cnt - 1'b1;
  end

  assign buzzer = (buzz_cnt != '0);
  assign pts_a  = pts[0];
  assign pts_b  = pts[1];
  assign pts_c  = pts[2];

endmodule

// File: tb/tb_placar_registro_pontos.sv
// Bench for placar_registro_pontos: behavioural score model checked every
// cycle plus directed scenarios with literal expectations.
module tb_placar_registro_pontos;

  localparam int DEB  = 16;
  localparam int MAXS = 99;
  localparam int BUZZ = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_a_n = 1'b1;
  logic btn_b_n = 1'b1;
  logic btn_c_n = 1'b1;
  logic team_sel = 1'b0;
  logic sub_mode = 1'b0;
  logic clear_n = 1'b1;
  logic [6:0] sum_s;
  logic sum_cout;
  logic pts_a, pts_b, pts_c;
  logic [6:0] n1;
  logic cin_o, team_o, buzzer;
  logic [6:0] score0, score1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  placar_registro_pontos #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_SCORE(MAXS),
    .BUZZ_CYCLES(BUZZ)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_a_n(btn_a_n),
    .btn_b_n(btn_b_n),
    .btn_c_n(btn_c_n),
    .team_sel(team_sel),
    .sub_mode(sub_mode),
    .clear_n(clear_n),
    .sum_s(sum_s),
    .sum_cout(sum_cout),
    .pts_a(pts_a),
    .pts_b(pts_b),
    .pts_c(pts_c),
    .n1(n1),
    .cin_o(cin_o),
    .team_o(team_o),
    .score0(score0),
    .score1(score1),
    .buzzer(buzzer)
  );

  // Stand-in for the encoder + 7-bit adder downstream.
  logic [6:0] opb;
  logic [7:0] add_r;
  always_comb begin
    opb = 7'd0;
    if (pts_a)      opb = 7'd1;
    else if (pts_b) opb = 7'd2;
    else if (pts_c) opb = 7'd3;
    add_r = {1'b0, n1} + {1'b0, (cin_o ? ~opb : opb)} + {7'd0, cin_o};
  end
  assign sum_s    = add_r[6:0];
  assign sum_cout = add_r[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: button history, operation age, plain integer scores.
  bit md[3], mp[3], ms1[3], ms2[3];
  logic [DEB-1:0] mh[3];
  int  m_age;
  bit  m_hold;
  int  m_pts;
  bit  m_team, m_cin;
  int  m_sc[2];
  int  m_buzz;

  always @(posedge clk or negedge rst_n) begin
    bit raw[3];
    bit ev, rej;
    int n, first, r;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        md[i] = 0; mp[i] = 0; ms1[i] = 0; ms2[i] = 0; mh[i] = '0;
      end
      m_age = 0; m_hold = 0; m_pts = 0; m_team = 0; m_cin = 0;
      m_sc[0] = 0; m_sc[1] = 0; m_buzz = 0;
    end else begin
      raw[0] = !btn_a_n; raw[1] = !btn_b_n; raw[2] = !btn_c_n;
      ev = 0; n = 0; first = 0; rej = 0;
      for (int i = 0; i < 3; i++) begin
        if (md[i] && !mp[i]) ev = 1;
        if (md[i]) begin
          if (n == 0) first = i;
          n++;
        end
      end
      if (!clear_n) begin
        m_sc[0] = 0; m_sc[1] = 0;
        m_age = 0; m_hold = 1; m_pts = 0;
      end else if (m_age == 2) begin
        r = m_sc[m_team] + (m_cin ? -m_pts : m_pts);
        if (r >= 0 && r <= MAXS) m_sc[m_team] = r;
        else rej = 1;
        m_age = 0; m_hold = 1; m_pts = 0;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_hold) begin
        if (n == 0) m_hold = 0;
      end else if (ev) begin
        if (n == 1) begin
          m_age = 1; m_pts = first + 1;
          m_team = team_sel; m_cin = sub_mode;
        end else begin
          m_hold = 1;
        end
      end
      if (rej) m_buzz = BUZZ;
      else if (m_buzz > 0) m_buzz--;
      for (int i = 0; i < 3; i++) begin
        mp[i] = md[i];
        mh[i] = {mh[i][DEB-2:0], ms2[i]};
        if (mh[i] == '1 && !md[i]) md[i] = 1;
        else if (mh[i] == '0 && md[i]) md[i] = 0;
        ms2[i] = ms1[i];
        ms1[i] = raw[i];
      end
    end
  end

  int pts_hi = 0;
  int buzz_hi = 0;

  always @(posedge clk) begin
    bit idle, ta;
    #1;
    if (rst_n) begin
      idle = (m_age == 0) && !m_hold;
      ta   = idle ? team_sel : m_team;
      chk("pts_a", int'(pts_a), int'(m_age != 0 && m_pts == 1));
      chk("pts_b", int'(pts_b), int'(m_age != 0 && m_pts == 2));
      chk("pts_c", int'(pts_c), int'(m_age != 0 && m_pts == 3));
      chk("team_o", int'(team_o), int'(ta));
      chk("n1", int'(n1), m_sc[ta]);
      chk("cin_o", int'(cin_o), int'(m_cin));
      chk("score0", int'(score0), m_sc[0]);
      chk("score1", int'(score1), m_sc[1]);
      chk("buzzer", int'(buzzer), int'(m_buzz != 0));
      if (pts_a | pts_b | pts_c) pts_hi++;
      if (buzzer) buzz_hi++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic [2:0] p);
    btn_a_n = !p[0];
    btn_b_n = !p[1];
    btn_c_n = !p[2];
  endtask

  task automatic press(input logic [2:0] p, input int hold);
    set_btn(p);
    cyc(hold);
    set_btn(3'b000);
    cyc(30);
  endtask

  task automatic wait_pts(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pts_a | pts_b | pts_c) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int p0, b0;
    bit ok;
    set_btn(3'b000);
    cyc(5);
    chk("rst_score0", int'(score0), 0);
    chk("rst_score1", int'(score1), 0);
    chk("rst_pts", int'({pts_a, pts_b, pts_c}), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_cin", int'(cin_o), 0);
    chk("rst_team", int'(team_o), 0);
    rst_n = 1'b1;
    cyc(5);

    p0 = pts_hi;
    press(3'b010, 3 * DEB);
    chk("t1_score0", int'(score0), 2);
    chk("t1_score1", int'(score1), 0);
    chk("t1_buzzer", int'(buzzer), 0);
    chk("t1_pts_cycles", pts_hi - p0, 2);

    team_sel = 1'b1;
    repeat (32) press(3'b100, 25);
    press(3'b010, 25);
    chk("t2_pre_score1", int'(score1), 98);
    b0 = buzz_hi;
    press(3'b100, 25);
    chk("t2_score1", int'(score1), 98);
    chk("t2_buzz_cycles", buzz_hi - b0, 8);

    team_sel = 1'b0;
    sub_mode = 1'b1;
    press(3'b001, 25);
    chk("t3_score0_1", int'(score0), 1);
    b0 = buzz_hi;
    press(3'b010, 25);
    chk("t3_borrow_score0", int'(score0), 1);
    chk("t3_buzz_cycles", buzz_hi - b0, 8);
    press(3'b001, 25);
    chk("t3_score0_0", int'(score0), 0);

    sub_mode = 1'b0;
    p0 = pts_hi;
    for (int i = 0; i < 40; i++) begin
      btn_a_n = ~btn_a_n;
      cyc(5);
    end
    set_btn(3'b000);
    cyc(30);
    chk("t4_no_pts", pts_hi - p0, 0);
    chk("t4_score0", int'(score0), 0);
    chk("t4_score1", int'(score1), 98);

    p0 = pts_hi;
    set_btn(3'b101);
    cyc(25);
    set_btn(3'b001);
    cyc(1000);
    set_btn(3'b000);
    cyc(30);
    chk("t5_no_pts", pts_hi - p0, 0);
    chk("t5_score0_pre", int'(score0), 0);
    press(3'b001, 25);
    chk("t5_score0", int'(score0), 1);

    team_sel = 1'b0;
    set_btn(3'b001);
    wait_pts(ok);
    chk("t6_wait_op1", int'(ok), 1);
    team_sel = 1'b1;
    cyc(1);
    chk("t6_team_held", int'(team_o), 0);
    cyc(20);
    set_btn(3'b000);
    cyc(30);
    chk("t6_score0", int'(score0), 2);
    chk("t6_score1", int'(score1), 98);

    set_btn(3'b010);
    wait_pts(ok);
    chk("t6_wait_op2", int'(ok), 1);
    clear_n = 1'b0;
    cyc(1);
    clear_n = 1'b1;
    cyc(5);
    set_btn(3'b000);
    cyc(30);
    chk("t6_clr_score0", int'(score0), 0);
    chk("t6_clr_score1", int'(score1), 0);
    press(3'b100, 25);
    chk("t6_after_clr", int'(score1), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/placar_registro_pontos.md
Name: placar_registro_pontos

Overview:
- Sequential stage upstream of the points-entry/adder/display path; it also closes the loop with that path.
- Debounces the three raw point buttons and turns each clean press into a one-shot point request.
- Drives the request to the button encoder and presents the selected team's stored score as the adder's N1 operand.
- Writes the adder result (S, Cout) back into the per-team score register, or rejects it and pulses the buzzer.

Parameters:
- DEBOUNCE_CYCLES, 16, stable-sample count needed to accept a button level change.
- MAX_SCORE, 99, largest storable score; must fit the 7-bit score path.
- BUZZ_CYCLES, 8, buzzer pulse length, in clocks, on a rejected operation.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_a_n  input  1  raw 1-point button, active-low, asynchronous to clk.
- btn_b_n  input  1  raw 2-point button, active-low, asynchronous to clk.
- btn_c_n  input  1  raw 3-point button, active-low, asynchronous to clk.
- team_sel  input  1  live team select (0 = team 0, 1 = team 1).
- sub_mode  input  1  0 = add, 1 = subtract; passed through as the adder carry-in.
- clear_n  input  1  synchronous active-low clear of both scores; level-sensed.
- sum_s  input  7  adder result S.
- sum_cout  input  1  adder carry-out.
- pts_a  output  1  one-hot point request to the encoder (1 point).
- pts_b  output  1  one-hot point request to the encoder (2 points).
- pts_c  output  1  one-hot point request to the encoder (3 points).
- n1  output  7  stored score of the active team, fed to the adder A operand.
- cin_o  output  1  registered copy of sub_mode, taken when a press is accepted.
- team_o  output  1  team shown by the display decoder.
- score0  output  7  team 0 score register.
- score1  output  7  team 1 score register.
- buzzer  output  1  high for BUZZ_CYCLES after a rejected operation.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - score0 = score1 = 0; pts_* = 0; buzzer = 0; cin_o = 0; team_o = 0.
  - State = IDLE; debounce counters cleared; debounced levels = released.
- Synchronisation and debounce:
  - Each raw button passes through a 2-flop synchroniser.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
  - A press event is the debounced released-to-pressed edge.
- Active team:
  - team_o = n1 team = live team_sel in IDLE.
  - In every other state it is the team latched at press acceptance.
  - n1 = score0 or score1 of the active team.
- FSM states: IDLE, SETTLE, COMMIT, WAIT_REL.
  - IDLE:
    - Press event with exactly one debounced button pressed: latch team_sel and sub_mode, assert the matching pts_* one-hot, go to SETTLE.
    - More than one button pressed at the event: no request, go to WAIT_REL.
  - SETTLE (1 cycle): hold pts_* and the latches while the combinational adder settles.
  - COMMIT (1 cycle): evaluate the sum.
    - Add (cin_o = 0): accept if sum_cout = 0 and sum_s ≤ MAX_SCORE.
    - Subtract (cin_o = 1): accept if sum_cout = 1, i.e. no borrow.
    - Accept: write sum_s into the latched team's register at the end of the cycle.
    - Reject: register unchanged; load the buzzer counter with BUZZ_CYCLES.
    - Either way go to WAIT_REL.
  - WAIT_REL: pts_* = 0; stay until all three debounced buttons are released, then go to IDLE. Holding a button produces exactly one operation.
- Latency: accepted debounced edge to updated score = 3 clocks (IDLE → SETTLE → COMMIT, register write at the end of COMMIT).
- Timing of latched inputs: team_sel and sub_mode changes after acceptance do not affect the operation in flight.
- Buzzer: buzzer = 1 while its counter is nonzero. A new reject reloads the counter to BUZZ_CYCLES.
- clear_n = 0:
  - Zeroes both scores every cycle it is low.
  - Forces the FSM to WAIT_REL from any state, aborting any operation in flight; no write occurs.
  - Has priority over a COMMIT in the same cycle.
- Reset mid-operation: immediate return to the reset values; the pending write is lost.
- No wrap-around: a stored score never exceeds MAX_SCORE and never goes below 0.

Test Plan:
- Reset, team_sel=0, add: press B (held 3·DEBOUNCE_CYCLES) → pts_b pulses for 2 cycles; score0 = 2 at 3 clocks after the debounced edge; score1 = 0; buzzer = 0.
- score1 = 98, team_sel=1, add, press C → sum_s = 101 > 99, rejected; score1 stays 98; buzzer high for exactly 8 clocks.
- score0 = 1, subtract, press B → sum_cout = 0 (borrow), rejected with buzzer; then press A → score0 = 0, accepted.
- Glitchy press: btn_a_n toggled every 5 clocks (< DEBOUNCE_CYCLES) for 200 clocks → no pts_* asserted, scores unchanged.
- A and C pressed together, then A held for 1000 clocks → no operation; after full release, a single press of A adds exactly 1.
- Press A with team_sel=0, flip team_sel to 1 during SETTLE, and pulse clear_n during a second operation's SETTLE:
  - First press → score0 incremented, team_o held at 0 until WAIT_REL.
  - Clear → both scores 0, no write from the aborted second operation.
